// File: rtl/riscv_core_pkg.sv
// Shared core types and constants: refill arbiter state encoding, default burst length, address/word types.
package riscv_core_pkg;

  localparam int unsigned XLEN              = 32;
  localparam int unsigned DEFAULT_BURST_LEN = 4;

  typedef logic [XLEN-1:0] addr_t;
  typedef logic [XLEN-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above the pointer, wrapping to the lowest one.
module rr_arbiter #(
  parameter int unsigned N  = 2,
  parameter int unsigned GW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [GW-1:0] i_ptr,
  output logic          o_valid,
  output logic [GW-1:0] o_idx
);

  logic          w_up_v;
  logic [GW-1:0] w_up_idx;
  logic [GW-1:0] w_low_idx;

  // Descending scan leaves the lowest qualifying index in each candidate.
  always_comb begin
    o_valid   = 1'b0;
    w_up_v    = 1'b0;
    w_up_idx  = '0;
    w_low_idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_valid   = 1'b1;
        w_low_idx = GW'(i);
        if (i >= int'(i_ptr)) begin
          w_up_v   = 1'b1;
          w_up_idx = GW'(i);
        end
      end
    end
    o_idx = w_up_v ? w_up_idx : w_low_idx;
  end

endmodule

// File: rtl/l1_mem_arbiter.sv
// Round-robin arbiter granting icache/dcache refill bursts onto one memory port.
// Optional L1_ARB_PERF_EN adds per-requester grant and wait counters.
module l1_mem_arbiter
  import riscv_core_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned BURST_LEN  = DEFAULT_BURST_LEN,
  parameter int unsigned ADDR_WIDTH = 32,
  localparam int unsigned GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NUM_REQ-1:0]                   req_valid_i,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr_i,
  output logic [NUM_REQ-1:0]                   req_ready_o,
  output logic [NUM_REQ-1:0]                   rsp_valid_o,
  output word_t                                rsp_data_o,
  output logic                                 mem_req_valid_o,
  output logic [ADDR_WIDTH-1:0]                mem_req_addr_o,
  input  logic                                 mem_req_ready_i,
  input  logic                                 mem_rsp_valid_i,
  input  word_t                                mem_rsp_data_i,
  output logic [GW-1:0]                        grant_o,
  output logic                                 busy_o
`ifdef L1_ARB_PERF_EN
  ,
  output logic [NUM_REQ-1:0][31:0]             perf_grant_cnt_o,
  output logic [NUM_REQ-1:0][31:0]             perf_wait_cnt_o
`endif
);

  localparam int unsigned BW = $clog2(BURST_LEN) + 1;

  arb_state_e            r_state, w_state_nxt;
  logic [GW-1:0]         r_grant, w_grant_nxt;
  logic [GW-1:0]         r_rr_ptr, w_rr_ptr_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [BW-1:0]         r_beat, w_beat_nxt;
  logic [BW-1:0]         w_beat_inc;
  logic                  w_pick_valid;
  logic [GW-1:0]         w_pick_idx;

  rr_arbiter #(
    .N  (NUM_REQ),
    .GW (GW)
  ) u_rr_arbiter (
    .i_req   (req_valid_i),
    .i_ptr   (r_rr_ptr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_addr   <= '0;
      r_beat   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_addr   <= w_addr_nxt;
      r_beat   <= w_beat_nxt;
    end
  end

  assign w_beat_inc = r_beat + BW'(1);

  // Next state plus the zero-latency handshake/response routing toward the owner.
  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_addr_nxt      = r_addr;
    w_beat_nxt      = r_beat;
    req_ready_o     = '0;
    rsp_valid_o     = '0;
    rsp_data_o      = '0;
    mem_req_valid_o = 1'b0;
    mem_req_addr_o  = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_grant_nxt = w_pick_idx;
          w_addr_nxt  = req_addr_i[w_pick_idx];
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        mem_req_valid_o      = 1'b1;
        mem_req_addr_o       = r_addr;
        req_ready_o[r_grant] = mem_req_ready_i;
        if (mem_req_ready_i) begin
          w_beat_nxt  = '0;
          w_state_nxt = ST_RSP;
        end
      end
      ST_RSP: begin
        rsp_valid_o[r_grant] = mem_rsp_valid_i;
        rsp_data_o           = mem_rsp_data_i;
        if (mem_rsp_valid_i) begin
          w_beat_nxt = w_beat_inc;
          if (w_beat_inc == BW'(BURST_LEN)) begin
            w_state_nxt  = ST_IDLE;
            w_rr_ptr_nxt = (r_grant == GW'(NUM_REQ - 1)) ? '0 : r_grant + GW'(1);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign grant_o = r_grant;
  assign busy_o  = (r_state != ST_IDLE);

`ifdef L1_ARB_PERF_EN
  logic [NUM_REQ-1:0][31:0] r_perf_grant;
  logic [NUM_REQ-1:0][31:0] r_perf_wait;

  // Saturating counters; a requester is not waiting while it owns the port in REQ/RSP.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_perf_grant <= '0;
      r_perf_wait  <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (r_state == ST_REQ && mem_req_ready_i && r_grant == GW'(i) &&
            r_perf_grant[i] != '1) begin
          r_perf_grant[i] <= r_perf_grant[i] + 32'd1;
        end
        if (req_valid_i[i] && !(r_state != ST_IDLE && r_grant == GW'(i)) &&
            r_perf_wait[i] != '1) begin
          r_perf_wait[i] <= r_perf_wait[i] + 32'd1;
        end
      end
    end
  end

  assign perf_grant_cnt_o = r_perf_grant;
  assign perf_wait_cnt_o  = r_perf_wait;
`endif

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Self-checking bench for l1_mem_arbiter: directed scenarios plus randomized bursts against a round-robin model.
module tb_l1_mem_arbiter;

  localparam int unsigned NUM_REQ   = 2;
  localparam int unsigned BURST_LEN = 4;
  localparam int unsigned AW        = 32;

  logic                    clk_i = 1'b0;
  logic                    rst_ni;
  logic [NUM_REQ-1:0]      req_valid_i;
  logic [NUM_REQ-1:0][AW-1:0] req_addr_i;
  logic [NUM_REQ-1:0]      req_ready_o;
  logic [NUM_REQ-1:0]      rsp_valid_o;
  logic [31:0]             rsp_data_o;
  logic                    mem_req_valid_o;
  logic [AW-1:0]           mem_req_addr_o;
  logic                    mem_req_ready_i;
  logic                    mem_rsp_valid_i;
  logic [31:0]             mem_rsp_data_i;
  logic [0:0]              grant_o;
  logic                    busy_o;
`ifdef L1_ARB_PERF_EN
  logic [NUM_REQ-1:0][31:0] perf_grant_cnt_o;
  logic [NUM_REQ-1:0][31:0] perf_wait_cnt_o;
`endif

  int checks = 0;
  int errors = 0;
  int unsigned model_ptr = 0;

  always #5 clk_i = ~clk_i;

  l1_mem_arbiter #(.NUM_REQ(NUM_REQ), .BURST_LEN(BURST_LEN), .ADDR_WIDTH(AW)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .req_valid_i     (req_valid_i),
    .req_addr_i      (req_addr_i),
    .req_ready_o     (req_ready_o),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_data_o      (rsp_data_o),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_data_i  (mem_rsp_data_i),
    .grant_o         (grant_o),
    .busy_o          (busy_o)
`ifdef L1_ARB_PERF_EN
    ,
    .perf_grant_cnt_o(perf_grant_cnt_o),
    .perf_wait_cnt_o (perf_wait_cnt_o)
`endif
  );

  task automatic idle_inputs();
    req_valid_i     = '0;
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i  = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk_i);
    rst_ni    = 1'b1;
    model_ptr = 0;
  endtask

  // Round-robin rule: first valid requester at or above ptr, with wrap-around.
  function automatic int unsigned model_pick(input logic [NUM_REQ-1:0] v, input int unsigned ptr);
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    end
    return 0;
  endfunction

  task automatic test_reset();
    rst_ni = 1'b0;
    idle_inputs();
    req_valid_i     = 2'b11;
    req_addr_i[0]   = 32'h1111_0000;
    req_addr_i[1]   = 32'h2222_0000;
    mem_req_ready_i = 1'b1;
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk_i);
    #1;
    checks++;
    if ({req_ready_o, rsp_valid_o, mem_req_valid_o, busy_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got rdy=%b rsp=%b mreq=%b busy=%b want all 0",
               req_ready_o, rsp_valid_o, mem_req_valid_o, busy_o);
    end
    checks++;
    if (rsp_data_o !== 32'h0 || mem_req_addr_o !== 32'h0 || grant_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_data got data=%h addr=%h grant=%0d want 0", rsp_data_o, mem_req_addr_o, grant_o);
    end
    @(negedge clk_i);
    idle_inputs();
    rst_ni    = 1'b1;
    model_ptr = 0;
  endtask

  task automatic test_single_req();
    int pulses = 0;
    @(negedge clk_i);
    req_valid_i   = 2'b01;
    req_addr_i[0] = 32'h0000_1000;
    req_addr_i[1] = 32'h0000_2000;
    #1;
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL single_idle busy=%b want 0", busy_o); end
    @(negedge clk_i);
    mem_req_ready_i = 1'b1;
    #1;
    checks++;
    if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== 32'h1000 || req_ready_o !== 2'b01) begin
      errors++;
      $display("FAIL single_req got v=%b addr=%h rdy=%b want 1 00001000 01",
               mem_req_valid_o, mem_req_addr_o, req_ready_o);
    end
    for (int k = 0; k < int'(BURST_LEN); k++) begin
      @(negedge clk_i);
      req_valid_i     = '0;
      mem_req_ready_i = 1'b0;
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = 32'hA000_0000 + 32'(k);
      #1;
      if (rsp_valid_o === 2'b01) pulses++;
      checks++;
      if (rsp_data_o !== 32'hA000_0000 + 32'(k)) begin
        errors++;
        $display("FAIL single_data beat %0d got %h want %h", k, rsp_data_o, 32'hA000_0000 + 32'(k));
      end
    end
    checks++;
    if (pulses != int'(BURST_LEN)) begin
      errors++; $display("FAIL single_pulses got %0d want %0d", pulses, BURST_LEN);
    end
    @(negedge clk_i);
    idle_inputs();
    #1;
    checks++;
    if (busy_o !== 1'b0 || rsp_valid_o !== 2'b00) begin
      errors++; $display("FAIL single_done busy=%b rsp=%b want 0 00", busy_o, rsp_valid_o);
    end
    model_ptr = 1;
  endtask

  task automatic test_contention();
    int unsigned grants[$];
    int rsp_cnt[2] = '{0, 0};
    int idle_gap = 0;
    apply_reset();
    @(negedge clk_i);
    req_valid_i     = 2'b11;
    req_addr_i[0]   = 32'h0000_4000;
    req_addr_i[1]   = 32'h0000_8000;
    mem_req_ready_i = 1'b1;
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = 32'h1234_5678;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk_i);
      #1;
      if (mem_req_valid_o) grants.push_back(int'(grant_o));
      if (grants.size() == 1 && !busy_o) idle_gap++;
      if (rsp_valid_o[0]) rsp_cnt[0]++;
      if (rsp_valid_o[1]) rsp_cnt[1]++;
    end
    checks++;
    if (grants.size() != 2 || grants[0] != model_pick(2'b11, 0) || grants[1] != model_pick(2'b11, 1)) begin
      errors++;
      $display("FAIL contention_order got n=%0d g0=%0d g1=%0d want 0 then 1",
               grants.size(), grants.size() > 0 ? grants[0] : 9, grants.size() > 1 ? grants[1] : 9);
    end
    checks++;
    if (idle_gap != 1) begin errors++; $display("FAIL contention_gap got %0d idle want 1", idle_gap); end
    checks++;
    if (rsp_cnt[0] != 4 || rsp_cnt[1] != 4) begin
      errors++; $display("FAIL contention_rsp got %0d/%0d want 4/4", rsp_cnt[0], rsp_cnt[1]);
    end
    idle_inputs();
  endtask

  task automatic test_stall();
    int beats = 0;
    apply_reset();
    @(negedge clk_i);
    req_valid_i   = 2'b01;
    req_addr_i[0] = 32'h0000_3000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      mem_req_ready_i = 1'b0;
      #1;
      checks++;
      if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== 32'h3000 || req_ready_o !== 2'b00) begin
        errors++;
        $display("FAIL stall_hold cyc %0d got v=%b addr=%h rdy=%b want 1 00003000 00",
                 k, mem_req_valid_o, mem_req_addr_o, req_ready_o);
      end
    end
    @(negedge clk_i);
    mem_req_ready_i = 1'b1;
    #1;
    checks++;
    if (req_ready_o !== 2'b01 || mem_req_addr_o !== 32'h3000) begin
      errors++; $display("FAIL stall_accept got rdy=%b addr=%h want 01 00003000", req_ready_o, mem_req_addr_o);
    end
    for (int c = 0; c < 20 && beats < int'(BURST_LEN); c++) begin
      @(negedge clk_i);
      req_valid_i     = '0;
      mem_req_ready_i = 1'b0;
      mem_rsp_valid_i = c[0];
      #1;
      if (mem_rsp_valid_i) beats++;
    end
    @(negedge clk_i);
    idle_inputs();
    #1;
    checks++;
    if (beats != int'(BURST_LEN) || busy_o !== 1'b0) begin
      errors++; $display("FAIL stall_done beats=%0d busy=%b want %0d 0", beats, busy_o, BURST_LEN);
    end
    model_ptr = 1;
  endtask

  task automatic test_rsp_in_idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      idle_inputs();
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = 32'hCAFE_0000 + 32'(k);
      #1;
      checks++;
      if (rsp_valid_o !== 2'b00 || busy_o !== 1'b0 || mem_req_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL idle_rsp cyc %0d got rsp=%b busy=%b mreq=%b want 00 0 0",
                 k, rsp_valid_o, busy_o, mem_req_valid_o);
      end
    end
    @(negedge clk_i);
    idle_inputs();
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    @(negedge clk_i);
    req_valid_i   = 2'b01;
    req_addr_i[0] = 32'h0000_6000;
    @(negedge clk_i);
    mem_req_ready_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      mem_req_ready_i = 1'b0;
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = 32'h5555_0000 + 32'(k);
    end
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({req_ready_o, rsp_valid_o, mem_req_valid_o, busy_o} !== 6'b0 ||
        rsp_data_o !== 32'h0 || mem_req_addr_o !== 32'h0 || grant_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs got rdy=%b rsp=%b mreq=%b busy=%b data=%h addr=%h grant=%0d want 0",
               req_ready_o, rsp_valid_o, mem_req_valid_o, busy_o, rsp_data_o, mem_req_addr_o, grant_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle_inputs();
    model_ptr = 0;
    mem_rsp_valid_i = 1'b1;
    #1;
    checks++;
    if (rsp_valid_o !== 2'b00) begin errors++; $display("FAIL midrst_norsp got %b want 00", rsp_valid_o); end
    @(negedge clk_i);
    idle_inputs();
    req_valid_i   = 2'b10;
    req_addr_i[1] = 32'h0000_5000;
    @(negedge clk_i);
    mem_req_ready_i = 1'b1;
    #1;
    checks++;
    if (mem_req_valid_o !== 1'b1 || grant_o !== 1'b1 || mem_req_addr_o !== 32'h5000 || req_ready_o !== 2'b10) begin
      errors++;
      $display("FAIL midrst_regrant got v=%b g=%0d addr=%h rdy=%b want 1 1 00005000 10",
               mem_req_valid_o, grant_o, mem_req_addr_o, req_ready_o);
    end
    for (int k = 0; k < int'(BURST_LEN); k++) begin
      @(negedge clk_i);
      req_valid_i     = '0;
      mem_req_ready_i = 1'b0;
      mem_rsp_valid_i = 1'b1;
    end
    @(negedge clk_i);
    idle_inputs();
    model_ptr = 0;
  endtask

  task automatic test_random();
    logic [NUM_REQ-1:0] v;
    int unsigned g, d, beats;
    logic [31:0] a0, a1, exp_addr;
    apply_reset();
    for (int b = 0; b < 30; b++) begin
      @(negedge clk_i);
      idle_inputs();
      v  = NUM_REQ'($urandom_range(1, 3));
      a0 = $urandom & 32'hFFFF_FFF0;
      a1 = $urandom & 32'hFFFF_FFF0;
      req_valid_i   = v;
      req_addr_i[0] = a0;
      req_addr_i[1] = a1;
      g = model_pick(v, model_ptr);
      exp_addr = (g == 0) ? a0 : a1;
      #1;
      checks++;
      if (busy_o !== 1'b0) begin errors++; $display("FAIL rand_idle burst %0d busy=%b want 0", b, busy_o); end
      d = $urandom_range(0, 3);
      for (int k = 0; k <= int'(d); k++) begin
        @(negedge clk_i);
        req_valid_i     = NUM_REQ'($urandom_range(0, 3));
        mem_req_ready_i = (k == int'(d));
        mem_rsp_valid_i = $urandom_range(0, 1);
        #1;
        checks++;
        if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== exp_addr || int'(grant_o) != int'(g) ||
            req_ready_o !== (mem_req_ready_i ? NUM_REQ'(1 << g) : NUM_REQ'(0)) || rsp_valid_o !== 2'b00) begin
          errors++;
          $display("FAIL rand_req burst %0d got v=%b addr=%h g=%0d rdy=%b rsp=%b want 1 %h %0d",
                   b, mem_req_valid_o, mem_req_addr_o, grant_o, req_ready_o, rsp_valid_o, exp_addr, g);
        end
      end
      beats = 0;
      for (int c = 0; c < 40 && beats < BURST_LEN; c++) begin
        @(negedge clk_i);
        req_valid_i     = NUM_REQ'($urandom_range(0, 3));
        mem_req_ready_i = $urandom_range(0, 1);
        mem_rsp_valid_i = (c >= 30) ? 1'b1 : 1'($urandom_range(0, 1));
        mem_rsp_data_i  = $urandom;
        #1;
        checks++;
        if (rsp_valid_o !== (mem_rsp_valid_i ? NUM_REQ'(1 << g) : NUM_REQ'(0)) ||
            (mem_rsp_valid_i && rsp_data_o !== mem_rsp_data_i) || mem_req_valid_o !== 1'b0) begin
          errors++;
          $display("FAIL rand_rsp burst %0d got rsp=%b data=%h mreq=%b want owner %0d data %h",
                   b, rsp_valid_o, rsp_data_o, mem_req_valid_o, g, mem_rsp_data_i);
        end
        if (mem_rsp_valid_i) beats++;
      end
      checks++;
      if (beats != BURST_LEN) begin errors++; $display("FAIL rand_timeout burst %0d beats %0d want %0d", b, beats, BURST_LEN); end
      model_ptr = (g + 1) % NUM_REQ;
    end
    @(negedge clk_i);
    idle_inputs();
  endtask

`ifdef L1_ARB_PERF_EN
  task automatic test_perf();
    apply_reset();
    @(negedge clk_i);
    req_valid_i   = 2'b01;
    req_addr_i[0] = 32'h0000_1000;
    req_addr_i[1] = 32'h0000_2000;
    @(negedge clk_i);
    req_valid_i     = 2'b00;
    mem_req_ready_i = 1'b1;
    for (int k = 0; k < int'(BURST_LEN); k++) begin
      @(negedge clk_i);
      req_valid_i     = 2'b10;
      mem_req_ready_i = 1'b0;
      mem_rsp_valid_i = 1'b1;
    end
    @(negedge clk_i);
    mem_rsp_valid_i = 1'b0;
    @(negedge clk_i);
    req_valid_i     = 2'b00;
    mem_req_ready_i = 1'b1;
    for (int k = 0; k < int'(BURST_LEN); k++) begin
      @(negedge clk_i);
      mem_req_ready_i = 1'b0;
      mem_rsp_valid_i = 1'b1;
    end
    @(negedge clk_i);
    idle_inputs();
    #1;
    checks++;
    if (perf_wait_cnt_o[1] !== 32'd5 || perf_wait_cnt_o[0] !== 32'd1) begin
      errors++; $display("FAIL perf_wait got %0d/%0d want 1/5", perf_wait_cnt_o[0], perf_wait_cnt_o[1]);
    end
    checks++;
    if (perf_grant_cnt_o[0] !== 32'd1 || perf_grant_cnt_o[1] !== 32'd1) begin
      errors++; $display("FAIL perf_grant got %0d/%0d want 1/1", perf_grant_cnt_o[0], perf_grant_cnt_o[1]);
    end
  endtask
`endif

  initial begin
    req_addr_i = '0;
    test_reset();
    test_single_req();
    test_contention();
    test_stall();
    test_rsp_in_idle();
    test_reset_mid_burst();
    test_random();
`ifdef L1_ARB_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
